hazard_control: RTL and testbench

- Pipeline hazard controller that consumes the control and register fields leaving the ID/EX latch and drives the hold/bubble/flush controls back into PC, IF/ID and ID/EX.
- Detects load-use hazards (stall) and taken branch/jump in EX (flush).
- Holds each condition for a parameterised number of cycles via an internal FSM and counter.
- Sits beside the ID/EX latch in the 5-stage MIPS datapath.

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/hazard_detect.sv | 28 ++
 rtl/hazard_control.sv | 169 ++++++++++++++++
 tb/tb_hazard_control.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared encodings for the 5-stage MIPS pipeline control logic (rev 1.0).
`default_nettype none

package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use and redirect detection for the ID/EX boundary (rev 1.0).
`default_nettype none

module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_MemRead,
  input  logic [4:0] ex_rt,
  input  logic       ex_branch,
  input  logic       ex_zero,
  input  logic       ex_jump,
  output logic       load_use,
  output logic       redirect
);

  always_comb begin
    redirect = ex_jump | (ex_branch & ex_zero);
    // $0 is hard-wired, so a load targeting it can never create a dependency
    load_use = ex_MemRead & (ex_rt != REG_ZERO) &
               ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  end

endmodule

`default_nettype wire

// File: rtl/hazard_control.sv
// hazard_control: stall/flush sequencer driving PC, IF/ID and ID/EX controls (rev 1.0).
// Optional perf counters (stall_cnt, flush_cnt, perf_clr) enabled by HAZARD_PERF_CNT_EN.
`default_nettype none

module hazard_control
  import pipeline_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int PERF_CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_MemRead,
  input  logic [4:0] ex_rt,
  input  logic       ex_branch,
  input  logic       ex_zero,
  input  logic       ex_jump,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt,
  input  logic                  perf_clr
`endif
);

  localparam logic [3:0] STALL_LOAD = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  generate
    if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 15 ||
        FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || PERF_CNT_W < 1) begin : g_param_check
      $error("hazard_control: parameter out of legal range");
    end
  endgenerate

  hz_state_t  state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       load_use, redirect;
  logic       stall_act, flush_act;

  hazard_detect u_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_MemRead (ex_MemRead),
    .ex_rt      (ex_rt),
    .ex_branch  (ex_branch),
    .ex_zero    (ex_zero),
    .ex_jump    (ex_jump),
    .load_use   (load_use),
    .redirect   (redirect)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    stall_act   = 1'b0;
    flush_act   = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    busy        = (state != RUN);

    case (state)
      RUN: begin
        if (redirect) begin
          flush_act = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nx = FLUSH;
            cnt_nx   = FLUSH_LOAD;
          end
        end else if (load_use) begin
          stall_act = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_nx = STALL;
            cnt_nx   = STALL_LOAD;
          end
        end
      end
      STALL: begin
        // A redirect makes the stalled instruction dead, so drop the stall
        if (redirect) begin
          flush_act = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nx = FLUSH;
            cnt_nx   = FLUSH_LOAD;
          end else begin
            state_nx = RUN;
            cnt_nx   = 4'd0;
          end
        end else begin
          stall_act = 1'b1;
          cnt_nx    = cnt - 4'd1;
          if (cnt == 4'd1) state_nx = RUN;
        end
      end
      FLUSH: begin
        flush_act = 1'b1;
        cnt_nx    = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = RUN;
      end
      default: begin
        state_nx = RUN;
        cnt_nx   = 4'd0;
      end
    endcase

    if (flush_act) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
    if (stall_act) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end

    // Outputs are forced to a safe squash pattern while reset is held
    if (!reset_n) begin
      stall_act   = 1'b0;
      flush_act   = 1'b0;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      busy        = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (perf_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_act && (stall_cnt != {PERF_CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + PERF_CNT_W'(1);
      if (flush_act && (flush_cnt != {PERF_CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + PERF_CNT_W'(1);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_control.sv
// tb_hazard_control: table, directed and randomized checks of hazard_control against a cycle model.
`default_nettype none

module tb_hazard_control;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic       id_uses_rt = 1'b0, ex_MemRead = 1'b0;
  logic       ex_branch = 1'b0, ex_zero = 1'b0, ex_jump = 1'b0;
  logic       perf_clr = 1'b0;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, busy}
  logic [4:0] out_a, out_b, out_c;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] sc_a, fc_a, sc_c, fc_c;
  logic [1:0]  sc_b, fc_b;
`endif

  hazard_control #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .PERF_CNT_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .ex_branch(ex_branch), .ex_zero(ex_zero),
    .ex_jump(ex_jump), .pc_write(out_a[4]), .ifid_write(out_a[3]), .ifid_flush(out_a[2]),
    .idex_bubble(out_a[1]), .busy(out_a[0])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(sc_a), .flush_cnt(fc_a), .perf_clr(perf_clr)
`endif
  );

  hazard_control #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .PERF_CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .ex_branch(ex_branch), .ex_zero(ex_zero),
    .ex_jump(ex_jump), .pc_write(out_b[4]), .ifid_write(out_b[3]), .ifid_flush(out_b[2]),
    .idex_bubble(out_b[1]), .busy(out_b[0])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(sc_b), .flush_cnt(fc_b), .perf_clr(perf_clr)
`endif
  );

  hazard_control #(.LOAD_STALL_CYCLES(4), .FLUSH_CYCLES(1), .PERF_CNT_W(16)) dut_c (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .ex_branch(ex_branch), .ex_zero(ex_zero),
    .ex_jump(ex_jump), .pc_write(out_c[4]), .ifid_write(out_c[3]), .ifid_flush(out_c[2]),
    .idex_bubble(out_c[1]), .busy(out_c[0])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(sc_c), .flush_cnt(fc_c), .perf_clr(perf_clr)
`endif
  );

  // Model state: remaining stall/flush cycles after the current one, perf counts
  typedef struct {
    int sl;
    int fl;
    int sc;
    int fc;
  } mst_t;

  mst_t m_a = '{0, 0, 0, 0};
  mst_t m_b = '{0, 0, 0, 0};
  mst_t m_c = '{0, 0, 0, 0};

  typedef struct {
    logic [4:0] rs, rt;
    logic       uses, mr;
    logic [4:0] ert;
    logic       br, z, j;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[12];

  function automatic void model(input mst_t s, input int lc, input int fcy, input int w,
                                output logic [4:0] o, output mst_t n);
    bit red, lu, sa, fa;
    int maxv;
    maxv = (1 << w) - 1;
    red  = ex_jump || (ex_branch && ex_zero);
    lu   = ex_MemRead && (ex_rt != 0) && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    n  = s;
    sa = 0;
    fa = 0;
    if (!reset_n) begin
      o = 5'b00110;
      n = '{0, 0, 0, 0};
      return;
    end
    if (s.fl > 0) begin
      o = 5'b11111; n.fl = s.fl - 1; fa = 1;
    end else if (red) begin
      o = {4'b1111, (s.sl > 0)}; n.fl = fcy - 1; n.sl = 0; fa = 1;
    end else if (s.sl > 0) begin
      o = 5'b00011; n.sl = s.sl - 1; sa = 1;
    end else if (lu) begin
      o = 5'b00010; n.sl = lc - 1; sa = 1;
    end else begin
      o = 5'b11000;
    end
    if (perf_clr) begin
      n.sc = 0;
      n.fc = 0;
    end else begin
      if (sa) n.sc = (s.sc < maxv) ? s.sc + 1 : maxv;
      if (fa) n.fc = (s.fc < maxv) ? s.fc + 1 : maxv;
    end
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                     input logic mr, input logic [4:0] ert, input logic br,
                     input logic z, input logic j);
    id_rs = rs; id_rt = rt; id_uses_rt = uses; ex_MemRead = mr;
    ex_rt = ert; ex_branch = br; ex_zero = z; ex_jump = j;
  endtask

  task automatic idle();
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge
  task automatic cycle(input string tag, input bit ka, input logic [4:0] xa,
                       input bit kb, input logic [4:0] xb,
                       input bit kc, input logic [4:0] xc);
    logic [4:0] ea, eb, ec;
    mst_t na, nb, nc;
    @(negedge clk);
    if (!reset_n) begin
      m_a = '{0, 0, 0, 0};
      m_b = '{0, 0, 0, 0};
      m_c = '{0, 0, 0, 0};
    end
    model(m_a, 1, 1, 16, ea, na);
    model(m_b, 3, 2, 2, eb, nb);
    model(m_c, 4, 1, 16, ec, nc);
    check({tag, "/mdl_a"}, 32'(out_a), 32'(ea));
    check({tag, "/mdl_b"}, 32'(out_b), 32'(eb));
    check({tag, "/mdl_c"}, 32'(out_c), 32'(ec));
`ifdef HAZARD_PERF_CNT_EN
    check({tag, "/stall_cnt_a"}, 32'(sc_a), m_a.sc);
    check({tag, "/flush_cnt_a"}, 32'(fc_a), m_a.fc);
    check({tag, "/stall_cnt_b"}, 32'(sc_b), m_b.sc);
    check({tag, "/flush_cnt_b"}, 32'(fc_b), m_b.fc);
    check({tag, "/stall_cnt_c"}, 32'(sc_c), m_c.sc);
    check({tag, "/flush_cnt_c"}, 32'(fc_c), m_c.fc);
`endif
    if (ka) check({tag, "/a"}, 32'(out_a), 32'(xa));
    if (kb) check({tag, "/b"}, 32'(out_b), 32'(xb));
    if (kc) check({tag, "/c"}, 32'(out_c), 32'(xc));
    @(posedge clk);
    m_a = na;
    m_b = nb;
    m_c = nc;
    #1;
  endtask

  initial begin
    // rs, rt, uses, memread, ex_rt, branch, zero, jump, expected dut_a outputs
    tbl[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11000};
    tbl[1]  = '{5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 5'b00010};
    tbl[2]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11000};
    tbl[3]  = '{5'd4, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 5'b11000};
    tbl[4]  = '{5'd4, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 5'b00010};
    tbl[5]  = '{5'd8, 5'd8, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 5'b11000};
    tbl[6]  = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b1, 5'b11110};
    tbl[7]  = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 5'b11110};
    tbl[8]  = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 5'b11000};
    tbl[9]  = '{5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, 5'b11110};
    tbl[10] = '{5'd3, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1, 1'b0, 5'b11000};
    tbl[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11000};

    // Reset with random inputs
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
          5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      cycle("reset", 1, 5'b00110, 1, 5'b00110, 1, 5'b00110);
    end
    reset_n = 1'b1;
    idle();
    cycle("post_reset", 1, 5'b11000, 1, 5'b11000, 1, 5'b11000);

    // Single-cycle table against the LOAD_STALL_CYCLES=1 / FLUSH_CYCLES=1 instance
    for (int i = 0; i < 12; i++) begin
      drv(tbl[i].rs, tbl[i].rt, tbl[i].uses, tbl[i].mr, tbl[i].ert, tbl[i].br, tbl[i].z, tbl[i].j);
      cycle($sformatf("tbl%0d", i), 1, tbl[i].exp, 0, 5'd0, 0, 5'd0);
    end

    // Three-cycle load-use stall
    idle();
    for (int i = 0; i < 5; i++) cycle("settle1", 0, 5'd0, 0, 5'd0, 0, 5'd0);
    drv(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    cycle("ls3_c1", 1, 5'b00010, 1, 5'b00010, 1, 5'b00010);
    idle();
    cycle("ls3_c2", 1, 5'b11000, 1, 5'b00011, 1, 5'b00011);
    cycle("ls3_c3", 1, 5'b11000, 1, 5'b00011, 1, 5'b00011);
    cycle("ls3_done", 1, 5'b11000, 1, 5'b11000, 0, 5'd0);

    // Jump aborts a four-cycle stall in its second cycle
    for (int i = 0; i < 5; i++) cycle("settle2", 0, 5'd0, 0, 5'd0, 0, 5'd0);
    drv(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    cycle("abort_c1", 0, 5'd0, 0, 5'd0, 1, 5'b00010);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cycle("abort_c2", 1, 5'b11110, 1, 5'b11111, 1, 5'b11111);
    idle();
    cycle("abort_c3", 1, 5'b11000, 0, 5'd0, 1, 5'b11000);

    // Reset in the middle of a stall
    for (int i = 0; i < 5; i++) cycle("settle3", 0, 5'd0, 0, 5'd0, 0, 5'd0);
    drv(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    cycle("rst_mid_c1", 0, 5'd0, 0, 5'd0, 1, 5'b00010);
    idle();
    cycle("rst_mid_c2", 0, 5'd0, 0, 5'd0, 1, 5'b00011);
    reset_n = 1'b0;
    cycle("rst_mid_rst", 1, 5'b00110, 1, 5'b00110, 1, 5'b00110);
    reset_n = 1'b1;
    cycle("rst_mid_run", 1, 5'b11000, 1, 5'b11000, 1, 5'b11000);

`ifdef HAZARD_PERF_CNT_EN
    perf_clr = 1'b1;
    cycle("pclr0", 0, 5'd0, 0, 5'd0, 0, 5'd0);
    perf_clr = 1'b0;
    check("perf_clr0_stall", 32'(sc_a), 32'd0);
    check("perf_clr0_flush", 32'(fc_a), 32'd0);
    for (int i = 0; i < 5; i++) begin
      drv(5'd4, 5'd12, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0);
      cycle("perf_ld", 0, 5'd0, 0, 5'd0, 0, 5'd0);
      idle();
      cycle("perf_idle", 0, 5'd0, 0, 5'd0, 0, 5'd0);
    end
    for (int i = 0; i < 2; i++) begin
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
      cycle("perf_br", 0, 5'd0, 0, 5'd0, 0, 5'd0);
      idle();
      cycle("perf_idle", 0, 5'd0, 0, 5'd0, 0, 5'd0);
    end
    check("perf_stall5", 32'(sc_a), 32'd5);
    check("perf_flush2", 32'(fc_a), 32'd2);
    check("perf_sat_w2", 32'(sc_b), 32'd3);
    perf_clr = 1'b1;
    cycle("pclr1", 0, 5'd0, 0, 5'd0, 0, 5'd0);
    perf_clr = 1'b0;
    check("perf_clr1_stall", 32'(sc_a), 32'd0);
    check("perf_clr1_flush", 32'(fc_a), 32'd0);
    check("perf_clr1_stall_b", 32'(sc_b), 32'd0);
`endif

    // Randomized traffic with narrow register fields so matches are frequent
    for (int i = 0; i < 3000; i++) begin
      reset_n  = ($urandom_range(0, 99) >= 2);
      perf_clr = ($urandom_range(0, 99) < 3);
      drv(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
          1'($urandom), 5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 3),
          1'($urandom), ($urandom_range(0, 9) == 0));
      cycle("rand", 0, 5'd0, 0, 5'd0, 0, 5'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
